// File: rtl/mem_req_arbiter_pkg.sv
// mem_req_arbiter_pkg
// Shared definitions for the memory request arbiter:
//   - FSM state encodings (arb_state_t)
//   - grant-id encodings (GID_INST, GID_DATA)
//   - sram-like transfer size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD)
//   - pickGrant(): chooses the winner among the currently requesting ports
// No ports; imported with "import mem_req_arbiter_pkg::*;".
package mem_req_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  localparam logic GID_INST = 1'b0;
  localparam logic GID_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // A lone requester always wins. When both ports request, prefInst
  // decides whether inst beats data (data wins otherwise).
  function automatic logic pickGrant(input logic instReq,
                                     input logic dataReq,
                                     input logic prefInst);
    if (instReq && (!dataReq || prefInst))
      return GID_INST;
    else
      return GID_DATA;
  endfunction

endpackage

// File: rtl/mem_req_arbiter_fifo.sv
// arb_id_fifo
// Order FIFO of 1-bit grant ids. The memory answers in request order, so
// the head entry always names the port that owns the next response.
// Ports:
//   clk, resetn      clock, synchronous active-low reset
//   i_push/i_pushId  enqueue the id of a request just accepted by memory
//   i_pop            dequeue the head (caller guarantees count > 0)
//   o_headId         id at the head of the queue
//   o_count          number of stored ids, 0..DEPTH
module arb_id_fifo
  import mem_req_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_push,
  input  logic             i_pushId,
  input  logic             i_pop,
  output logic             o_headId,
  output logic [CNT_W-1:0] o_count
);

  logic             r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  // Pointers wrap at DEPTH rather than at a power of two, so DEPTH = 3
  // works as well as 1, 2 and 4.
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1))
      return '0;
    else
      return p + 1'b1;
  endfunction

  // Storage, pointers and occupancy. A simultaneous push and pop moves
  // both pointers and leaves the count where it was.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= GID_INST;
    end else begin
      if (i_push) begin
        r_mem[r_tail] <= i_pushId;
        r_tail        <= nextPtr(r_tail);
      end
      if (i_pop)
        r_head <= nextPtr(r_head);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_headId = r_mem[r_head];
  assign o_count  = r_count;

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
// Shares one sram-like memory port between an instruction port and a data
// port, keeping up to MAX_OUT (1..4) transactions in flight and routing
// responses back in request order.
// Ports:
//   clk, resetn                         clock, synchronous active-low reset
//   inst_* / data_* (req side)          sram-like requests, held until addr_ok
//   inst_addr_ok/data_addr_ok           request accepted
//   inst_data_ok/data_data_ok, *_rdata  response valid / data
//   mem_* (req side, out)               shared memory request
//   mem_addr_ok/mem_data_ok/mem_rdata   memory handshake and in-order responses
//   arb_err                             sticky: response with nothing in flight
// Configuration macro: ARB_ROUND_ROBIN_EN -- when defined, simultaneous
// requests go to the port not granted last; otherwise data beats inst.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int MAX_OUT = 2,
  localparam int CNT_W = $clog2(MAX_OUT + 1)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        arb_err
);

  arb_state_t       r_state;
  logic             r_gid;
  logic             r_arbErr;
  logic [CNT_W-1:0] w_count;
  logic             w_headId;
  logic             w_push;
  logic             w_pop;
  logic             w_canGrant;
  logic             w_prefInst;

  // A new grant needs a free FIFO slot; the count seen here is the value
  // before any pop in this cycle, so a slot freed by a response becomes
  // usable one cycle later.
  assign w_canGrant = (r_state == ST_IDLE) && (inst_req || data_req)
                      && (w_count < CNT_W'(MAX_OUT));
  assign w_push     = (r_state == ST_GRANT) && mem_addr_ok;
  assign w_pop      = mem_data_ok && (w_count != '0);

`ifdef ARB_ROUND_ROBIN_EN
  logic r_lastGid;

  // Remember who was granted last so a tie goes to the other port.
  always_ff @(posedge clk) begin
    if (!resetn)
      r_lastGid <= GID_INST;
    else if (w_push)
      r_lastGid <= r_gid;
  end

  assign w_prefInst = (r_lastGid == GID_DATA);
`else
  assign w_prefInst = 1'b0;
`endif

  // Two-state grant FSM. Leaving GRANT always passes through IDLE, which
  // gives the mandatory bubble between grants. A requester that drops req
  // in GRANT simply leaves the FSM waiting for mem_addr_ok.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_gid    <= GID_INST;
      r_arbErr <= 1'b0;
    end else begin
      if (mem_data_ok && (w_count == '0))
        r_arbErr <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_canGrant) begin
            r_state <= ST_GRANT;
            r_gid   <= pickGrant(inst_req, data_req, w_prefInst);
          end
        end
        ST_GRANT: begin
          if (w_push)
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  arb_id_fifo #(.DEPTH(MAX_OUT)) u_idFifo (
    .clk      (clk),
    .resetn   (resetn),
    .i_push   (w_push),
    .i_pushId (r_gid),
    .i_pop    (w_pop),
    .o_headId (w_headId),
    .o_count  (w_count)
  );

  // Memory-side request mirrors whichever port holds the grant; the
  // handshakes are steered to the granted port (addr_ok) and to the FIFO
  // head (data_ok).
  always_comb begin
    mem_req   = (r_state == ST_GRANT);
    mem_wr    = inst_wr;
    mem_size  = inst_size;
    mem_addr  = inst_addr;
    mem_wstrb = inst_wstrb;
    mem_wdata = inst_wdata;
    if (r_gid == GID_DATA) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_addr  = data_addr;
      mem_wstrb = data_wstrb;
      mem_wdata = data_wdata;
    end
    inst_addr_ok = w_push && (r_gid == GID_INST);
    data_addr_ok = w_push && (r_gid == GID_DATA);
    inst_data_ok = w_pop && (w_headId == GID_INST);
    data_data_ok = w_pop && (w_headId == GID_DATA);
  end

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;
  assign arb_err    = r_arbErr;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter
// Directed bench for mem_req_arbiter (MAX_OUT = 2). A transaction-level
// model (grant flag, queue of in-flight owners, sticky error) predicts
// every output each cycle; a few literal expectations pin key moments.
// Honours ARB_ROUND_ROBIN_EN for tie-breaking expectations.
module tb_mem_req_arbiter;

  localparam int MAX_OUT = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_req = 1'b0, inst_wr = 1'b0;
  logic [1:0]  inst_size = 2'd2;
  logic [31:0] inst_addr = 32'h1c000000;
  logic [3:0]  inst_wstrb = 4'hf;
  logic [31:0] inst_wdata = 32'h11111111;
  logic        data_req = 1'b0, data_wr = 1'b1;
  logic [1:0]  data_size = 2'd1;
  logic [31:0] data_addr = 32'h1c008000;
  logic [3:0]  data_wstrb = 4'h3;
  logic [31:0] data_wdata = 32'h22222222;
  logic        mem_addr_ok = 1'b0, mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        arb_err;

  int nChecks = 0;
  int nFail = 0;

  // Model state: is a port granted and which one, owners of in-flight
  // transactions in issue order, sticky error, last granted port.
  bit mArmed = 0;
  bit mGranted = 0;
  int mGid = 0;
  int mQ[$];
  bit mErr = 0;
  int mLast = 0;

  mem_req_arbiter #(.MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge.
  task automatic applyStimulus(input bit rstn, input bit ir, input bit dr,
                               input bit aok, input bit dok,
                               input logic [31:0] rd);
    @(posedge clk);
    #1;
    resetn      = rstn;
    inst_req    = ir;
    data_req    = dr;
    mem_addr_ok = aok;
    mem_data_ok = dok;
    mem_rdata   = rd;
  endtask

  // Every falling edge: compare outputs against the model, then advance
  // the model by the transaction events this cycle's inputs cause.
  always @(negedge clk) begin
    int sz0;
    bit hasHead;
    int head;
    hasHead = (mQ.size() > 0);
    head    = hasHead ? mQ[0] : 0;
    if (mArmed) begin
      checkOutput("mem_req", {31'd0, mem_req}, {31'd0, mGranted});
      if (mGranted) begin
        checkOutput("mem_addr", mem_addr, (mGid == 1) ? data_addr : inst_addr);
        checkOutput("mem_wdata", mem_wdata, (mGid == 1) ? data_wdata : inst_wdata);
        checkOutput("mem_ctl", {25'd0, mem_wr, mem_size, mem_wstrb},
                    (mGid == 1) ? {25'd0, data_wr, data_size, data_wstrb}
                                : {25'd0, inst_wr, inst_size, inst_wstrb});
      end
      checkOutput("inst_addr_ok", {31'd0, inst_addr_ok},
                  {31'd0, mGranted && mGid == 0 && mem_addr_ok});
      checkOutput("data_addr_ok", {31'd0, data_addr_ok},
                  {31'd0, mGranted && mGid == 1 && mem_addr_ok});
      checkOutput("inst_data_ok", {31'd0, inst_data_ok},
                  {31'd0, mem_data_ok && hasHead && head == 0});
      checkOutput("data_data_ok", {31'd0, data_data_ok},
                  {31'd0, mem_data_ok && hasHead && head == 1});
      checkOutput("inst_rdata", inst_rdata, mem_rdata);
      checkOutput("data_rdata", data_rdata, mem_rdata);
      checkOutput("arb_err", {31'd0, arb_err}, {31'd0, mErr});
    end
    if (!resetn) begin
      mGranted = 0;
      mGid     = 0;
      mQ.delete();
      mErr     = 0;
      mLast    = 0;
      mArmed   = 1;
    end else begin
      sz0 = mQ.size();
      if (mem_data_ok) begin
        if (sz0 > 0) void'(mQ.pop_front());
        else mErr = 1;
      end
      if (mGranted) begin
        if (mem_addr_ok) begin
          mQ.push_back(mGid);
          mLast    = mGid;
          mGranted = 0;
        end
      end else if ((inst_req || data_req) && sz0 < MAX_OUT) begin
        if (inst_req && data_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          mGid = (mLast == 1) ? 0 : 1;
`else
          mGid = 1;
`endif
        end else begin
          mGid = data_req ? 1 : 0;
        end
        mGranted = 1;
      end
    end
  end

  initial begin
    // Reset held two cycles.
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    checkOutput("lit_reset_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("lit_reset_arb_err", {31'd0, arb_err}, 32'd0);

    // Single inst read: grant, accept, respond.
    applyStimulus(1, 1, 0, 0, 0, 32'h0);
    applyStimulus(1, 1, 0, 1, 0, 32'h0);
    @(negedge clk);
    checkOutput("lit_inst_mem_req", {31'd0, mem_req}, 32'd1);
    checkOutput("lit_inst_mem_addr", mem_addr, 32'h1c000000);
    checkOutput("lit_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    applyStimulus(1, 0, 0, 0, 1, 32'h02c00000);
    @(negedge clk);
    checkOutput("lit_inst_data_ok", {31'd0, inst_data_ok}, 32'd1);
    checkOutput("lit_inst_rdata", inst_rdata, 32'h02c00000);

    // Both request: data first, bubble, then tie-break.
    applyStimulus(1, 1, 1, 0, 0, 32'h0);
    applyStimulus(1, 1, 1, 1, 0, 32'h0);
    @(negedge clk);
    checkOutput("lit_tie1_mem_addr", mem_addr, 32'h1c008000);
    checkOutput("lit_tie1_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    applyStimulus(1, 1, 1, 0, 0, 32'h0);
    @(negedge clk);
    checkOutput("lit_bubble_mem_req", {31'd0, mem_req}, 32'd0);
    applyStimulus(1, 1, 1, 1, 0, 32'h0);
    @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
    checkOutput("lit_tie2_mem_addr", mem_addr, 32'h1c000000);
`else
    checkOutput("lit_tie2_mem_addr", mem_addr, 32'h1c008000);
`endif

    // FIFO full: inst held off until a response frees a slot.
    applyStimulus(1, 1, 0, 0, 0, 32'h0);
    applyStimulus(1, 1, 0, 0, 0, 32'h0);
    @(negedge clk);
    checkOutput("lit_full_mem_req", {31'd0, mem_req}, 32'd0);
    applyStimulus(1, 1, 0, 0, 1, 32'haaaa0001);
    @(negedge clk);
    checkOutput("lit_full_pop_data_ok", {31'd0, data_data_ok}, 32'd1);
    checkOutput("lit_full_pop_mem_req", {31'd0, mem_req}, 32'd0);
    applyStimulus(1, 1, 0, 0, 0, 32'h0);
    // Push and pop together, then drain the remaining inst entry.
    applyStimulus(1, 1, 0, 1, 1, 32'hbbbb0002);
    @(negedge clk);
    checkOutput("lit_pushpop_mem_addr", mem_addr, 32'h1c000000);
    applyStimulus(1, 0, 0, 0, 1, 32'hcccc0003);
    @(negedge clk);
    checkOutput("lit_drain_inst_data_ok", {31'd0, inst_data_ok}, 32'd1);
    checkOutput("lit_drain_arb_err", {31'd0, arb_err}, 32'd0);

    // Spurious response with nothing in flight.
    applyStimulus(1, 0, 0, 0, 1, 32'hdddd0004);
    @(negedge clk);
    checkOutput("lit_spur_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    applyStimulus(1, 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    checkOutput("lit_spur_arb_err", {31'd0, arb_err}, 32'd1);

    // Reset mid-GRANT discards the grant and clears the error.
    applyStimulus(1, 0, 1, 0, 0, 32'h0);
    applyStimulus(1, 0, 1, 0, 0, 32'h0);
    @(negedge clk);
    checkOutput("lit_grant_mem_req", {31'd0, mem_req}, 32'd1);
    applyStimulus(0, 0, 1, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    checkOutput("lit_rst_arb_err", {31'd0, arb_err}, 32'd0);
    checkOutput("lit_rst_mem_req", {31'd0, mem_req}, 32'd0);
    applyStimulus(1, 0, 0, 0, 1, 32'h55550005);
    @(negedge clk);
    checkOutput("lit_rst_no_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    applyStimulus(1, 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    checkOutput("lit_rst_count_zero", {31'd0, arb_err}, 32'd1);

    // Back-to-back traffic with responses overlapping grants.
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    applyStimulus(1, 1, 0, 0, 0, 32'h0);
    applyStimulus(1, 1, 0, 1, 0, 32'h0);
    applyStimulus(1, 0, 1, 0, 0, 32'h0);
    applyStimulus(1, 0, 1, 0, 1, 32'h66660006);
    applyStimulus(1, 0, 1, 1, 0, 32'h0);
    applyStimulus(1, 1, 1, 0, 1, 32'h77770007);
    applyStimulus(1, 1, 1, 0, 0, 32'h0);
    applyStimulus(1, 1, 0, 1, 0, 32'h0);
    applyStimulus(1, 0, 0, 0, 1, 32'h88880008);
    applyStimulus(1, 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    checkOutput("lit_tail_arb_err", {31'd0, arb_err}, 32'd0);
    @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", nChecks, nFail);
    $finish;
  end

endmodule
